ahb_iopmp_viol: RTL and testbench

//  Sits on one IOPMP channel, between a DMA-side AHB master and the matching IOPMP slave port.

---
 rtl/ahb_iopmp_viol_pkg.sv | 37 +++
 rtl/ahb_iopmp_viol_fifo.sv | 54 +++++
 rtl/ahb_iopmp_viol.sv | 200 ++++++++++++++++++++
 tb/tb_ahb_iopmp_viol.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_iopmp_viol_pkg.sv
// Shared AHB enums, the violation-log entry type and config register offsets.
// IOPMP_VIOL_TS_EN adds a 32-bit push timestamp to each log entry.
package ahb_enum;

    typedef enum logic [1:0] {
        AHB_RESP_OKAY  = 2'b00,
        AHB_RESP_ERROR = 2'b01,
        AHB_RESP_RETRY = 2'b10,
        AHB_RESP_SPLIT = 2'b11
    } ahb_resp_e;

    typedef enum logic [1:0] {
        AHB_TRANS_IDLE   = 2'b00,
        AHB_TRANS_BUSY   = 2'b01,
        AHB_TRANS_NONSEQ = 2'b10,
        AHB_TRANS_SEQ    = 2'b11
    } ahb_trans_e;

    // Logged addresses are held at 32 bits regardless of the bus address width.
    localparam int VIOL_LOG_AW = 32;

    localparam logic [7:0] VIOL_REG_CTRL  = 8'h00;
    localparam logic [7:0] VIOL_REG_STAT  = 8'h04;
    localparam logic [7:0] VIOL_REG_HADDR = 8'h08;
    localparam logic [7:0] VIOL_REG_HINFO = 8'h0C;
    localparam logic [7:0] VIOL_REG_HTS   = 8'h10;

    typedef struct packed {
        logic [VIOL_LOG_AW-1:0] addr;
        logic                   hwrite;
        logic [2:0]             hsize;
`ifdef IOPMP_VIOL_TS_EN
        logic [31:0]            ts;
`endif
    } viol_entry_t;

endpackage

// File: rtl/ahb_iopmp_viol_fifo.sv
// Synchronous FIFO of violation log entries with flush; DEPTH must be a power of 2.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ahb_iopmp_viol_fifo
    import ahb_enum::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        push,
    input  logic        pop,
    input  logic        clr,
    input  viol_entry_t din,
    output viol_entry_t head,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    viol_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + 5'(do_push) - 5'(do_pop);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge hclk) begin
        if (do_push & ~clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ahb_iopmp_viol.sv
// IOPMP violation responder: turns denied transfers into a two-cycle AHB ERROR,
// logs them into a FIFO readable over a config port, and raises irq. Option: IOPMP_VIOL_TS_EN.
//
// state   | meaning
// PASS    | transparent pass-through between master and IOPMP slave port
// ERR1    | first ERROR cycle: hready low, downstream held IDLE
// ERR2    | second ERROR cycle: hready high, next address may be accepted
module ahb_iopmp_viol
    import ahb_enum::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [1:0]            hresp,
    output logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    input  logic [ADDR_WIDTH-1:0] s_haddr,
    input  logic [3:0]            s_hprot,
    input  logic [2:0]            s_hsize,
    input  logic [1:0]            s_htrans,
    input  logic [2:0]            s_hburst,
    input  logic                  s_hwrite,
    input  logic [DATA_WIDTH-1:0] s_hwdata,
    output logic [1:0]            s_hresp,
    output logic                  s_hready,
    output logic [DATA_WIDTH-1:0] s_hrdata,
    output logic [ADDR_WIDTH-1:0] m_haddr,
    output logic [3:0]            m_hprot,
    output logic [2:0]            m_hsize,
    output logic [1:0]            m_htrans,
    output logic [2:0]            m_hburst,
    output logic                  m_hwrite,
    output logic [DATA_WIDTH-1:0] m_hwdata,
    input  logic [1:0]            m_hresp,
    input  logic                  m_hready,
    input  logic [DATA_WIDTH-1:0] m_hrdata,
    input  logic                  pmp_deny,
    output logic                  irq
);
    typedef enum logic [1:0] {ST_PASS, ST_ERR1, ST_ERR2} state_e;

    state_e      state, state_nxt;
    logic        ready_int;
    logic        deny_hit;
    viol_entry_t push_entry;
    viol_entry_t head;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fifo_clr;
    logic        wr_pend;
    logic [7:0]  wr_addr;
    logic        irq_en;
    logic        ovf;
    logic [7:0]  drop;
    logic        rd_en;
    logic [31:0] rdata32;
    logic        unused_ok;

    assign unused_ok = ^{haddr[ADDR_WIDTH-1:8], hwdata[DATA_WIDTH-1:2]};

    // Kept separate from the output mux so accept does not loop through s_hready.
    assign ready_int = (state == ST_ERR1) ? 1'b0 :
                       (state == ST_ERR2) ? 1'b1 : m_hready;
    assign deny_hit  = ready_int & s_htrans[1] & pmp_deny;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= ST_PASS;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_hready  = ready_int;
        s_hresp   = m_hresp;
        s_hrdata  = m_hrdata;
        m_htrans  = pmp_deny ? AHB_TRANS_IDLE : s_htrans;
        case (state)
            ST_PASS: begin
                if (deny_hit) state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                s_hresp   = AHB_RESP_ERROR;
                s_hrdata  = '0;
                m_htrans  = AHB_TRANS_IDLE;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                s_hresp   = AHB_RESP_ERROR;
                s_hrdata  = '0;
                state_nxt = deny_hit ? ST_ERR1 : ST_PASS;
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    assign m_haddr  = s_haddr;
    assign m_hprot  = s_hprot;
    assign m_hsize  = s_hsize;
    assign m_hburst = s_hburst;
    assign m_hwrite = s_hwrite;
    assign m_hwdata = s_hwdata;

`ifdef IOPMP_VIOL_TS_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 32'd1;
    end
`endif

    always_comb begin
        push_entry        = '0;
        push_entry.addr   = VIOL_LOG_AW'(s_haddr);
        push_entry.hwrite = s_hwrite;
        push_entry.hsize  = s_hsize;
`ifdef IOPMP_VIOL_TS_EN
        push_entry.ts     = ts_cnt;
`endif
    end

    ahb_iopmp_viol_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .hclk   (hclk),
        .hreset (hreset),
        .push   (deny_hit),
        .pop    (fifo_pop),
        .clr    (fifo_clr),
        .din    (push_entry),
        .head   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign hready   = 1'b1;
    assign hresp    = AHB_RESP_OKAY;
    assign rd_en    = hsel & ~hwrite;
    assign fifo_pop = rd_en & (haddr[7:0] == VIOL_REG_HINFO);
    assign fifo_clr = wr_pend & (wr_addr == VIOL_REG_CTRL) & hwdata[1];

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_pend <= 1'b0;
            wr_addr <= '0;
            irq_en  <= 1'b0;
        end else begin
            wr_pend <= hsel & hwrite;
            wr_addr <= haddr[7:0];
            if (wr_pend && wr_addr == VIOL_REG_CTRL) irq_en <= hwdata[0];
        end
    end

    // A push that lands while full and without a simultaneous pop is lost.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ovf  <= 1'b0;
            drop <= '0;
        end else if (fifo_clr) begin
            ovf  <= 1'b0;
            drop <= '0;
        end else if (deny_hit && fifo_full && !(fifo_pop && !fifo_empty)) begin
            ovf <= 1'b1;
            if (drop != 8'hFF) drop <= drop + 8'd1;
        end
    end

    always_comb begin
        rdata32 = '0;
        case (haddr[7:0])
            VIOL_REG_CTRL:  rdata32 = {31'd0, irq_en};
            VIOL_REG_STAT:  rdata32 = {8'd0, drop, 5'd0, ovf, fifo_empty, fifo_full, 3'd0, fifo_count};
            VIOL_REG_HADDR: rdata32 = fifo_empty ? '0 : head.addr;
            VIOL_REG_HINFO: rdata32 = fifo_empty ? '0 : {28'd0, head.hwrite, head.hsize};
`ifdef IOPMP_VIOL_TS_EN
            VIOL_REG_HTS:   rdata32 = fifo_empty ? '0 : head.ts;
`endif
            default:        rdata32 = '0;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hrdata <= '0;
            irq    <= 1'b0;
        end else begin
            if (rd_en) hrdata <= DATA_WIDTH'(rdata32);
            irq <= irq_en & (~fifo_empty | ovf);
        end
    end

endmodule

// File: tb/tb_ahb_iopmp_viol.sv
// Directed bench for ahb_iopmp_viol: scoreboard queue of expected values plus a log model.
// Works with or without IOPMP_VIOL_TS_EN.
module tb_ahb_iopmp_viol;
    import ahb_enum::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          hsel, hwrite;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata, hrdata;
    logic [1:0]    hresp;
    logic          hready;
    logic [AW-1:0] s_haddr, m_haddr;
    logic [3:0]    s_hprot, m_hprot;
    logic [2:0]    s_hsize, m_hsize, s_hburst, m_hburst;
    logic [1:0]    s_htrans, m_htrans, s_hresp, m_hresp;
    logic          s_hwrite, m_hwrite, s_hready, m_hready;
    logic [DW-1:0] s_hwdata, m_hwdata, s_hrdata, m_hrdata;
    logic          pmp_deny, irq;

    always #5 hclk = ~hclk;

    ahb_iopmp_viol #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .hclk(hclk), .hreset(hreset),
        .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
        .hresp(hresp), .hready(hready), .hrdata(hrdata),
        .s_haddr(s_haddr), .s_hprot(s_hprot), .s_hsize(s_hsize), .s_htrans(s_htrans),
        .s_hburst(s_hburst), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
        .s_hresp(s_hresp), .s_hready(s_hready), .s_hrdata(s_hrdata),
        .m_haddr(m_haddr), .m_hprot(m_hprot), .m_hsize(m_hsize), .m_htrans(m_htrans),
        .m_hburst(m_hburst), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
        .m_hresp(m_hresp), .m_hready(m_hready), .m_hrdata(m_hrdata),
        .pmp_deny(pmp_deny), .irq(irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
    } ent_t;

    logic [31:0] exp_q[$];
    ent_t        log_q[$];
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic        m_irq_en;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rd;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic mdl_clear();
        log_q.delete();
        m_ovf  = 1'b0;
        m_drop = 8'd0;
    endtask

    task automatic mdl_push(input logic [31:0] a, input logic w, input logic [2:0] s);
        ent_t e;
        e.addr = a;
        e.wr   = w;
        e.size = s;
        if (log_q.size() < DEPTH) log_q.push_back(e);
        else begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop++;
        end
    endtask

    function automatic logic [31:0] mdl_reg(input logic [7:0] a);
        int n;
        n = log_q.size();
        case (a)
            VIOL_REG_CTRL:  return {31'd0, m_irq_en};
            VIOL_REG_STAT:  return {8'd0, m_drop, 5'd0, m_ovf, (n == 0), (n == DEPTH), 3'd0, 5'(n)};
            VIOL_REG_HADDR: return (n == 0) ? 32'd0 : log_q[0].addr;
            VIOL_REG_HINFO: return (n == 0) ? 32'd0 : {28'd0, log_q[0].wr, log_q[0].size};
            default:        return 32'd0;
        endcase
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        haddr = {24'd0, a}; hsel = 1'b1; hwrite = 1'b1;
        tick();
        hsel = 1'b0; hwrite = 1'b0; hwdata = d;
        tick();
        hwdata = '0;
        if (a == VIOL_REG_CTRL) begin
            m_irq_en = d[0];
            if (d[1]) mdl_clear();
        end
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        haddr = {24'd0, a}; hsel = 1'b1; hwrite = 1'b0;
        tick();
        hsel = 1'b0;
        d = hrdata;
        if (a == VIOL_REG_HINFO && log_q.size() > 0) log_q.delete(0);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a);
        logic [31:0] d;
        expect_val(mdl_reg(a));
        cfg_read(a, d);
        check(tag, d);
    endtask

    task automatic drive_idle();
        s_htrans = AHB_TRANS_IDLE;
        pmp_deny = 1'b0;
    endtask

    // One denied NONSEQ from PASS, returning to PASS three cycles later.
    task automatic deny_xfer(input logic [31:0] a, input logic w, input logic [2:0] s);
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = a; s_hwrite = w; s_hsize = s; pmp_deny = 1'b1;
        mdl_push(a, w, s);
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1;
        hsel = 0; hwrite = 0; haddr = '0; hwdata = '0;
        s_haddr = '0; s_hprot = 4'h3; s_hsize = 3'd2; s_htrans = AHB_TRANS_IDLE;
        s_hburst = 3'd0; s_hwrite = 0; s_hwdata = '0;
        m_hresp = AHB_RESP_OKAY; m_hready = 1'b1; m_hrdata = '0; pmp_deny = 1'b0;
        m_irq_en = 1'b0;
        mdl_clear();
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        tick();

        // reset state
        expect_val(32'd0); check("rst_irq", {31'd0, irq});
        expect_val(32'd0); check("rst_hrdata", hrdata);
        m_hready = 1'b0; m_hresp = AHB_RESP_ERROR; settle();
        expect_val(32'd0); check("rst_s_hready_follow", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("rst_s_hresp_follow", {30'd0, s_hresp});
        m_hready = 1'b1; m_hresp = AHB_RESP_OKAY; settle();
        expect_val(32'd1); check("rst_s_hready_high", {31'd0, s_hready});
        read_check("rst_stat", VIOL_REG_STAT);
        read_check("rst_ctrl", VIOL_REG_CTRL);

        // 1: denied NONSEQ read
        m_hrdata = 32'hDEAD_BEEF;
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = 32'h2000_0000; s_hwrite = 0; s_hsize = 3'd2;
        pmp_deny = 1'b1;
        mdl_push(32'h2000_0000, 1'b0, 3'd2);
        settle();
        expect_val(32'(AHB_TRANS_IDLE)); check("t1_m_htrans_addr", {30'd0, m_htrans});
        tick(); drive_idle(); settle();
        expect_val(32'd0); check("t1_err1_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("t1_err1_hresp", {30'd0, s_hresp});
        expect_val(32'd0); check("t1_err1_hrdata", s_hrdata);
        expect_val(32'(AHB_TRANS_IDLE)); check("t1_err1_m_htrans", {30'd0, m_htrans});
        tick(); settle();
        expect_val(32'd1); check("t1_err2_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("t1_err2_hresp", {30'd0, s_hresp});
        expect_val(32'd0); check("t1_err2_hrdata", s_hrdata);
        tick(); settle();
        expect_val(32'(AHB_RESP_OKAY)); check("t1_pass_hresp", {30'd0, s_hresp});
        expect_val(32'hDEAD_BEEF); check("t1_pass_hrdata", s_hrdata);
        expect_val(32'd0); check("t1_irq_disabled", {31'd0, irq});
        cfg_write(VIOL_REG_CTRL, 32'h1);
        tick();
        expect_val(32'd1); check("t1_irq_enabled", {31'd0, irq});
        read_check("t1_haddr", VIOL_REG_HADDR);
        read_check("t1_stat", VIOL_REG_STAT);
        read_check("t1_hinfo_pop", VIOL_REG_HINFO);
        tick();
        expect_val(32'd0); check("t1_irq_after_pop", {31'd0, irq});
        read_check("t1_stat_empty", VIOL_REG_STAT);

        // 2: allowed transfer with downstream wait states
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = 32'h1000_0040; s_hwrite = 0; settle();
        expect_val(32'(AHB_TRANS_NONSEQ)); check("t2_m_htrans", {30'd0, m_htrans});
        expect_val(32'h1000_0040); check("t2_m_haddr", m_haddr);
        tick(); drive_idle(); m_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_val(32'd0); check("t2_wait_hready", {31'd0, s_hready});
            tick();
        end
        m_hready = 1'b1; m_hrdata = 32'hCAFE_F00D; settle();
        expect_val(32'd1); check("t2_hready", {31'd0, s_hready});
        expect_val(32'hCAFE_F00D); check("t2_hrdata", s_hrdata);
        expect_val(32'(AHB_RESP_OKAY)); check("t2_hresp", {30'd0, s_hresp});
        m_hresp = AHB_RESP_ERROR; settle();
        expect_val(32'(AHB_RESP_ERROR)); check("t2_down_err_pass", {30'd0, s_hresp});
        tick(); m_hresp = AHB_RESP_OKAY;
        read_check("t2_stat_nolog", VIOL_REG_STAT);
        expect_val(32'd0); check("t2_irq", {31'd0, irq});

        // 3: back-to-back denied writes
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = 32'h3000_0000; s_hwrite = 1; s_hsize = 3'd2;
        pmp_deny = 1'b1;
        mdl_push(32'h3000_0000, 1'b1, 3'd2);
        settle();
        expect_val(32'(AHB_TRANS_IDLE)); check("t3_a_m_htrans", {30'd0, m_htrans});
        tick(); s_haddr = 32'h3000_0004; settle();
        expect_val(32'd0); check("t3_err1a_hready", {31'd0, s_hready});
        expect_val(32'(AHB_TRANS_IDLE)); check("t3_err1a_m_htrans", {30'd0, m_htrans});
        tick(); settle();
        mdl_push(32'h3000_0004, 1'b1, 3'd2);
        expect_val(32'd1); check("t3_err2a_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("t3_err2a_hresp", {30'd0, s_hresp});
        expect_val(32'(AHB_TRANS_IDLE)); check("t3_err2a_m_htrans", {30'd0, m_htrans});
        tick(); drive_idle(); settle();
        expect_val(32'd0); check("t3_err1b_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("t3_err1b_hresp", {30'd0, s_hresp});
        tick(); settle();
        expect_val(32'd1); check("t3_err2b_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_ERROR)); check("t3_err2b_hresp", {30'd0, s_hresp});
        tick(); settle();
        expect_val(32'(AHB_RESP_OKAY)); check("t3_pass_hresp", {30'd0, s_hresp});
        read_check("t3_stat_cnt2", VIOL_REG_STAT);
        read_check("t3_hinfo0", VIOL_REG_HINFO);
        read_check("t3_haddr1", VIOL_REG_HADDR);
        read_check("t3_hinfo1", VIOL_REG_HINFO);

        // 4: overflow, then clear
        for (int i = 0; i < 6; i++)
            deny_xfer(32'h4000_0000 + 32'(i) * 4, 1'b0, 3'd2);
        read_check("t4_stat_ovf", VIOL_REG_STAT);
        expect_val(32'd1); check("t4_irq", {31'd0, irq});
        cfg_write(VIOL_REG_CTRL, 32'h3);
        tick();
        expect_val(32'd0); check("t4_irq_cleared", {31'd0, irq});
        read_check("t4_stat_clr", VIOL_REG_STAT);
        read_check("t4_ctrl_selfclr", VIOL_REG_CTRL);

        // 5: pop and push in the same cycle while full
        for (int i = 0; i < 4; i++)
            deny_xfer(32'h5000_0000 + 32'(i) * 16, 1'(i), 3'(i % 3));
        read_check("t5_stat_full", VIOL_REG_STAT);
        expect_val(mdl_reg(VIOL_REG_HINFO));
        log_q.delete(0);
        haddr = {24'd0, VIOL_REG_HINFO}; hsel = 1'b1; hwrite = 1'b0;
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = 32'h5000_0100; s_hwrite = 0; s_hsize = 3'd1;
        pmp_deny = 1'b1;
        mdl_push(32'h5000_0100, 1'b0, 3'd1);
        tick();
        hsel = 1'b0; drive_idle();
        check("t5_hinfo_pop", hrdata);
        tick(); tick();
        read_check("t5_stat_noovf", VIOL_REG_STAT);
        read_check("t5_haddr_next", VIOL_REG_HADDR);

        // 6: async reset during ERR1
        m_hrdata = 32'h1234_5678;
        s_htrans = AHB_TRANS_NONSEQ; s_haddr = 32'h6000_0000; pmp_deny = 1'b1;
        tick(); drive_idle(); settle();
        expect_val(32'd0); check("t6_err1_hready", {31'd0, s_hready});
        hreset = 1'b1; settle();
        mdl_clear(); m_irq_en = 1'b0;
        expect_val(32'd1); check("t6_rst_hready", {31'd0, s_hready});
        expect_val(32'(AHB_RESP_OKAY)); check("t6_rst_hresp", {30'd0, s_hresp});
        expect_val(32'h1234_5678); check("t6_rst_hrdata", s_hrdata);
        expect_val(32'd0); check("t6_rst_irq", {31'd0, irq});
        hreset = 1'b0;
        tick();
        m_hready = 1'b0; settle();
        expect_val(32'd0); check("t6_pass_follow", {31'd0, s_hready});
        m_hready = 1'b1;
        deny_xfer(32'h7000_0000, 1'b0, 3'd2);
        read_check("t6_stat", VIOL_REG_STAT);
`ifdef IOPMP_VIOL_TS_EN
        expect_val(32'd1);
        cfg_read(VIOL_REG_HTS, rd);
        check("t6_hts_small_nonzero", {31'd0, (rd != 32'd0) && (rd < 32'd64)});
`else
        expect_val(32'd0);
        cfg_read(VIOL_REG_HTS, rd);
        check("t6_hts_zero", rd);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
